// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin write arbiter that shares one FIFO write port among NREQ
// producers. One producer is granted at a time and may deliver up to BURST
// words before the grant is given up. The arbiter drives the FIFO WR strobe
// and dataIn directly from the granted producer and stalls while the FIFO
// reports FULL.
//
// Handshake (all producer ports): a word moves on a rising Clk edge when
// req_valid[i] and req_ready[i] are both high in the cycle before that edge.
// A producer raises valid with its data and must hold both unchanged until
// the edge where it sees ready; ready never depends on the producer's own
// valid, so there is no combinational loop through the producer.
//
// Parameters
//   NREQ   number of producers, power of two in 2..8
//   DW     data width, matches the FIFO dataIn
//   BURST  maximum words per grant, 1..15
//
// Ports
//   Clk         in   system clock, rising edge
//   Rst         in   asynchronous active-low reset
//   req_valid   in   [NREQ]      per-producer word valid
//   req_data    in   [NREQ*DW]   packed words, producer i at [i*DW +: DW]
//   req_ready   out  [NREQ]      per-producer accept, at most one bit high
//   fifo_full   in   FIFO FULL flag, used combinationally
//   fifo_wr     out  FIFO WR strobe, high exactly on accepted beats
//   fifo_data   out  [DW]        FIFO dataIn, granted producer's word
//   grant_id    out  [clog2(NREQ)] current or last granted producer
//   grant_busy  out  high while a grant is active; this is the FSM state
//                    (IDLE = 0, XFER = 1) and serves as its debug view
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int DW    = 32,
  parameter  int BURST = 4,
  localparam int IW    = $clog2(NREQ),
  localparam int CW    = $clog2(BURST + 1)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [DW-1:0]     fifo_data,
  output logic [IW-1:0]     grant_id,
  output logic              grant_busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] last_q,  last_d;   // producer that held the previous grant
  logic [IW-1:0] grant_q, grant_d;  // producer holding / last holding the grant
  logic [CW-1:0] cnt_q,   cnt_d;    // beats taken in the current grant

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand;
  logic          g_valid;
  logic          beat;

  // ---------------------------------------------------------------------------
  // Round-robin pick: scan last+1, last+2, ... wrapping through last itself.
  // NREQ is a power of two, so plain IW-bit addition wraps the index for free;
  // the final iteration (i == NREQ) truncates to last, which lets the previous
  // owner win again when it is the only one asking.
  // ---------------------------------------------------------------------------
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    cand       = last_q;
    for (int i = 1; i <= NREQ; i++) begin
      cand = last_q + IW'(i);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Granted producer's valid, and whether a word moves this cycle.
  // FULL blocks the beat in the same cycle it rises.
  assign g_valid = req_valid[grant_q];
  assign beat    = (state_q == ST_XFER) && g_valid && !fifo_full;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(NREQ - 1);  // makes producer 0 the first winner
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        // A released valid ends the grant even while FULL is stalling it.
        if (!g_valid) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end else if (beat) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BURST - 1)) begin
            state_d = ST_IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. Everything is decoded from state_q, so an asynchronous reset
  // drops ready/wr in the same cycle without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = '0;
    fifo_wr   = 1'b0;
    fifo_data = '0;
    if (state_q == ST_XFER) begin
      req_ready[grant_q] = !fifo_full;
      fifo_wr            = beat;
      fifo_data          = req_data[grant_q*DW +: DW];
    end
  end

  assign grant_id   = grant_q;
  assign grant_busy = (state_q == ST_XFER);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter with NREQ=4, DW=32, BURST=4.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Each clk_step call states the hand-derived ready vector,
// busy flag and grant_id for that cycle. Expected FIFO words are queued in
// exp_q in write order and popped whenever a write is expected. After an
// accepted word the bench advances that producer's data to its next word.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  logic         Clk;
  logic         Rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         fifo_full;
  logic         fifo_wr;
  logic [31:0]  fifo_data;
  logic [1:0]   grant_id;
  logic         grant_busy;

  int          n_assert;
  int          n_fail;
  int          wr_seen;
  int          wr_base;
  logic [31:0] exp_q[$];

  fifo_wr_arbiter #(
    .NREQ (4),
    .DW   (32),
    .BURST(4)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_data (fifo_data),
    .grant_id  (grant_id),
    .grant_busy(grant_busy)
  );

  // ---------------------------------------------------------------------------
  // Clock and watchdog
  // ---------------------------------------------------------------------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Driver and checker tasks
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int idx, input logic [31:0] val);
    req_data[idx*32 +: 32] = val;
  endtask

  task automatic push_seq(input logic [31:0] first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(first + 32'(k));
  endtask

  // One clock cycle: check outputs at the falling edge, then step past the
  // rising edge and advance any producer whose word was expected to move.
  task automatic clk_step(input string tag, input logic [3:0] e_ready,
                          input logic e_busy, input logic [1:0] e_gid);
    logic [3:0]  acc;
    logic [31:0] e_data;
    @(negedge Clk);
    acc = e_ready & req_valid;
    if (fifo_wr === 1'b1) wr_seen++;
    chk({tag, ".ready"}, 32'(req_ready),  32'(e_ready));
    chk({tag, ".busy"},  32'(grant_busy), 32'(e_busy));
    chk({tag, ".gid"},   32'(grant_id),   32'(e_gid));
    chk({tag, ".wr"},    32'(fifo_wr),    32'(|acc));
    if (|acc) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL %s.data: observed %0h expected nothing queued", tag, fifo_data);
      end else begin
        e_data = exp_q.pop_front();
        chk({tag, ".data"}, fifo_data, e_data);
      end
    end
    @(posedge Clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (acc[i]) req_data[i*32 +: 32] = req_data[i*32 +: 32] + 32'd1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    n_assert  = 0;
    n_fail    = 0;
    wr_seen   = 0;
    Rst       = 1'b1;
    req_valid = 4'hF;
    fifo_full = 1'b0;
    req_data  = '0;
    for (int i = 0; i < 4; i++) set_data(i, 32'hB000_0000 + 32'(i * 256));
    #2 Rst = 1'b0;

    // Reset with every producer asking: nothing may be accepted.
    clk_step("rst0", 4'b0000, 1'b0, 2'd0);
    clk_step("rst1", 4'b0000, 1'b0, 2'd0);
    Rst = 1'b1;

    // All four producers valid, FIFO never full: 0,1,2,3,0 with 4-beat
    // bursts and one IDLE cycle between grants.
    for (int g = 0; g < 4; g++) push_seq(32'hB000_0000 + 32'(g * 256), 4);
    exp_q.push_back(32'hB000_0004);
    wr_base = wr_seen;
    clk_step("a_idle0", 4'b0000, 1'b0, 2'd0);
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 4; b++)
        clk_step($sformatf("a_g%0d_b%0d", g, b), 4'(1 << g), 1'b1, 2'(g));
      clk_step($sformatf("a_gap%0d", g), 4'b0000, 1'b0, 2'(g));
    end
    chk("a_wr_count", 32'(wr_seen - wr_base), 32'd16);
    clk_step("a_g0_again", 4'b0001, 1'b1, 2'd0);
    req_valid = 4'b0000;
    clk_step("a_release", 4'b0001, 1'b1, 2'd0);
    clk_step("a_idle_end", 4'b0000, 1'b0, 2'd0);

    // Producer 2 alone: two bursts A0..A3 and A4..A7, then the FIFO is full.
    set_data(2, 32'h0000_00A0);
    push_seq(32'h0000_00A0, 8);
    req_valid = 4'b0100;
    clk_step("b_idle0", 4'b0000, 1'b0, 2'd0);
    for (int b = 0; b < 4; b++) clk_step($sformatf("b_p1_b%0d", b), 4'b0100, 1'b1, 2'd2);
    clk_step("b_gap", 4'b0000, 1'b0, 2'd2);
    for (int b = 0; b < 4; b++) clk_step($sformatf("b_p2_b%0d", b), 4'b0100, 1'b1, 2'd2);
    fifo_full = 1'b1;
    clk_step("b_full_idle", 4'b0000, 1'b0, 2'd2);
    clk_step("b_full0",     4'b0000, 1'b1, 2'd2);
    clk_step("b_full1",     4'b0000, 1'b1, 2'd2);
    // Release while FULL: the grant ends regardless of the stall.
    req_valid = 4'b0000;
    clk_step("b_drop_full", 4'b0000, 1'b1, 2'd2);
    clk_step("b_idle_end",  4'b0000, 1'b0, 2'd2);
    fifo_full = 1'b0;

    // Producer 1 with FULL for 3 cycles after 2 beats.
    set_data(1, 32'h0000_00C0);
    push_seq(32'h0000_00C0, 4);
    req_valid = 4'b0010;
    clk_step("c_idle", 4'b0000, 1'b0, 2'd2);
    clk_step("c_b0",   4'b0010, 1'b1, 2'd1);
    clk_step("c_b1",   4'b0010, 1'b1, 2'd1);
    fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) clk_step($sformatf("c_stall%0d", s), 4'b0000, 1'b1, 2'd1);
    fifo_full = 1'b0;
    clk_step("c_b2", 4'b0010, 1'b1, 2'd1);
    clk_step("c_b3", 4'b0010, 1'b1, 2'd1);
    req_valid = 4'b0000;
    clk_step("c_idle_end", 4'b0000, 1'b0, 2'd1);

    // Early release by producer 3 while producer 0 waits; 3 then waits its turn.
    set_data(3, 32'h0000_00D0);
    set_data(0, 32'h0000_00E0);
    exp_q.push_back(32'h0000_00D0);
    push_seq(32'h0000_00E0, 4);
    exp_q.push_back(32'h0000_00D1);
    exp_q.push_back(32'h0000_00E4);
    req_valid = 4'b1001;
    clk_step("d_idle",  4'b0000, 1'b0, 2'd1);
    clk_step("d_g3_b0", 4'b1000, 1'b1, 2'd3);
    req_valid = 4'b0001;
    clk_step("d_rel",   4'b1000, 1'b1, 2'd3);
    req_valid = 4'b1001;
    clk_step("d_idle2", 4'b0000, 1'b0, 2'd3);
    for (int b = 0; b < 4; b++) clk_step($sformatf("d_g0_b%0d", b), 4'b0001, 1'b1, 2'd0);
    clk_step("d_idle3",    4'b0000, 1'b0, 2'd0);
    clk_step("d_g3_again", 4'b1000, 1'b1, 2'd3);
    req_valid = 4'b0001;
    clk_step("d_rel2",  4'b1000, 1'b1, 2'd3);
    clk_step("d_idle4", 4'b0000, 1'b0, 2'd3);
    clk_step("d_g0_b0", 4'b0001, 1'b1, 2'd0);

    // Reset pulsed during beat 2 of producer 0's burst.
    req_valid = 4'b1001;
    #1;
    chk("e_pre_wr",   32'(fifo_wr), 32'd1);
    chk("e_pre_data", fifo_data,    32'h0000_00E5);
    Rst = 1'b0;
    #1;
    chk("e_rst_wr",    32'(fifo_wr),    32'd0);
    chk("e_rst_ready", 32'(req_ready),  32'd0);
    chk("e_rst_busy",  32'(grant_busy), 32'd0);
    chk("e_rst_gid",   32'(grant_id),   32'd0);
    clk_step("e_in_rst", 4'b0000, 1'b0, 2'd0);
    Rst = 1'b1;
    // Producers 0 and 3 both valid: restart from 0 even though 0 went last.
    exp_q.push_back(32'h0000_00E5);
    clk_step("e_idle", 4'b0000, 1'b0, 2'd0);
    clk_step("e_g0",   4'b0001, 1'b1, 2'd0);
    req_valid = 4'b0000;
    clk_step("e_rel", 4'b0001, 1'b1, 2'd0);
    clk_step("e_end", 4'b0000, 1'b0, 2'd0);

    chk("q_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
